multi_word_talker: RTL
======================

// Module: multi_word_talker
// PURPOSE
//  Parametrised successor of the single-shot talker FSM. Accepts DATA_W-bit words into a local FIFO
//  and transmits each word across a clock-domain boundary using a 4-phase req/ack handshake.
//  The block includes its own ack synchronizer. It sits on the sending side of a CDC link,
//  facing a listener in another clock domain.
// PARAMETERS
//  DATA_W       8    width of each transferred word (1..64)
//  DEPTH        4    FIFO depth in words; must be a power of 2, >= 2
//  SYNC_STAGES  2    flops in the ack_in synchronizer chain (>= 2)
//  TIMEOUT_CYC  255  cycles to wait per ack phase before error (used only with TALKER_TIMEOUT_EN)
// PORTS
//  clk        in   1                   single clock; all logic is rising-edge
//  reset      in   1                   synchronous, active-high
//  in_valid   in   1                   producer offers in_data
//  in_data    in   DATA_W              word to transmit
//  in_ready   out  1                   FIFO can accept; a word transfers when in_valid & in_ready
//  ack_in     in   1                   ack from the remote domain (asynchronous to clk)
//  req_out    out  1                   4-phase request (registered)
//  data_out   out  DATA_W              word under transfer (registered); stable while req_out=1 and until ack falls
//  busy       out  1                   FSM not IDLE, or FIFO not empty
//  level      out  $clog2(DEPTH)+1     FIFO occupancy, 0..DEPTH
//  err        out  1                   sticky ack-timeout flag
// BEHAVIOUR
//  Reset: FIFO empty, level=0, in_ready=1, req_out=0, data_out=0, busy=0, err=0, FSM=IDLE, sync chain=0.
//  Reset mid-transfer aborts immediately. Queued words are lost and req_out drops on the next edge.
//  FIFO rules:
//   - in_ready = !full. A push on full is ignored, even if a pop occurs in the same cycle.
//   - There is no empty-bypass path: a pushed word becomes visible the cycle after acceptance.
//   - Pointers wrap modulo DEPTH. Simultaneous push and pop keeps level unchanged.
//  ack_sync = ack_in delayed by SYNC_STAGES clk edges. The FSM sees only ack_sync.
//  FSM states:
//   - IDLE: if the FIFO is non-empty, load data_out with the head, pop, set req_out=1, go REQ_HI.
//   - REQ_HI: hold. When ack_sync=1, set req_out=0 and go ACK_WAIT_LO.
//   - ACK_WAIT_LO: when ack_sync=0, go IDLE. data_out holds its value until this exit.
//   - ERR: only with TALKER_TIMEOUT_EN.
//  Latency:
//   - req_out rises on the edge after the accept edge, when the FSM is IDLE and the FIFO was empty.
//   - At least one IDLE cycle separates successive words (ack_sync falls -> IDLE -> next req).
//  A spurious ack_sync=1 seen in IDLE is ignored. The next request still waits for ack_sync=0
//  through the normal sequence.
// CONFIGURATION
//  TALKER_TIMEOUT_EN defined:
//   - A counter runs in REQ_HI and ACK_WAIT_LO and restarts on each state entry.
//   - When it reaches TIMEOUT_CYC: req_out=0, err=1, go ERR. The in-flight word is dropped.
//   - ERR is terminal until reset. FIFO pushes still obey in_ready, and no word is sent.
//  TALKER_TIMEOUT_EN undefined:
//   - No counter and no ERR state. err is tied to 0. The FSM waits indefinitely.
// STRUCTURE
//  talker_pkg holds:
//   - typedef enum talker_state_t {IDLE, REQ_HI, ACK_WAIT_LO, ERR}
//   - localparams for the default widths
//   - function clog2_safe
//  One sub-module, ack_synchronizer #(SYNC_STAGES): a 1-bit flop chain with synchronous reset.
//  The FIFO (storage array plus pointers) and the FSM live in this module.
// TESTING
//  1. Single word: push 0xA5, remote acks 3 cycles after req. Expect req_out=1 on the edge after accept,
//     data_out=0xA5 held until ack falls, level 1->0.
//  2. Burst: push 0x01..0x06 back-to-back with DEPTH=4. Expect in_ready=0 once level=4,
//     words received in order 01..06, none lost or duplicated.
//  3. Full + pop together: level=4, the FSM pops and in_valid=1 in the same cycle. Expect the push rejected
//     and level=3.
//  4. Reset while req_out=1 in REQ_HI with 2 words queued. Expect req_out=0, level=0 and in_ready=1
//     after the reset edge, and no further req.
//  5. Ack hold: ack_in stays high 10 cycles. Expect req_out=0 after SYNC_STAGES+1 edges and the next
//     req not before ack_sync=0 plus one IDLE cycle.
//  6. [TALKER_TIMEOUT_EN, TIMEOUT_CYC=16] No ack. Expect err=1 and req_out=0 exactly 16 cycles after
//     req rises, and no later reqs.

Source files
------------

// File: rtl/multi_word_talker_pkg.sv
// talker_pkg: shared FSM state encoding, default widths and a sizing helper for multi_word_talker
package talker_pkg;
    typedef enum logic [1:0] {IDLE, REQ_HI, ACK_WAIT_LO, ERR} talker_state_t;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT_CYC = 255;
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/multi_word_talker_if.sv
// multi_word_talker_if: producer-side stream, CDC req/ack link and status of multi_word_talker
interface multi_word_talker_if
    import talker_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              ack_in;
    logic              req_out;
    logic [DATA_W-1:0] data_out;
    logic              busy;
    logic [$clog2(DEPTH):0] level;
    logic              err;
    modport master (output in_valid, in_data, ack_in, input in_ready, req_out, data_out, busy, level, err);
    modport slave  (input in_valid, in_data, ack_in, output in_ready, req_out, data_out, busy, level, err);
endinterface

// File: rtl/multi_word_talker_sync.sv
// ack_synchronizer: flop chain bringing the remote ack into the clk domain
module ack_synchronizer
    import talker_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);
    logic [SYNC_STAGES-1:0] chain;
    // Shift the asynchronous ack through the chain, cleared on reset
    always_ff @(posedge clk)
        chain <= reset ? '0 : {chain[SYNC_STAGES-2:0], async_in};
    assign sync_out = chain[SYNC_STAGES-1];
endmodule

// File: rtl/multi_word_talker.sv
// multi_word_talker: FIFO-buffered 4-phase req/ack sender for a CDC link; TALKER_TIMEOUT_EN adds an ack timeout with a terminal ERR state
module multi_word_talker
    import talker_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input logic clk,
    input logic reset,
    multi_word_talker_if.slave bus
);
    localparam int PTR_W = clog2_safe(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SYNC_STAGES < 2 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("multi_word_talker: invalid parameter set");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level;
    logic              ack_sync, full, empty, push, pop, expired;
    talker_state_t     state;

    assign full         = level == LVL_W'(DEPTH);
    assign empty        = level == '0;
    assign push         = bus.in_valid && !full;
    assign pop          = state == IDLE && !empty;
    assign bus.in_ready = !full;
    assign bus.level    = level;
    assign bus.busy     = state != IDLE || !empty;

    ack_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .reset(reset),
        .async_in(bus.ack_in),
        .sync_out(ack_sync)
    );

    // FIFO storage; a word written here is only readable from the next cycle
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= bus.in_data;

    // FIFO pointers and occupancy; a push on full is dropped even when a pop frees a slot
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

`ifdef TALKER_TIMEOUT_EN
    localparam int CNT_W = clog2_safe(TIMEOUT_CYC);
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    assign expired = cnt == CNT_W'(TIMEOUT_CYC - 1) &&
                     ((state == REQ_HI && !ack_sync) || (state == ACK_WAIT_LO && ack_sync));
    assign bus.err = err_q;
    // Per-phase wait counter, zero outside the ack phases and restarted on each phase entry
    always_ff @(posedge clk)
        cnt <= (reset || state == IDLE || state == ERR || (state == REQ_HI && ack_sync)) ? '0 : cnt + CNT_W'(1);
    // Sticky timeout flag, set on the same edge the FSM enters ERR
    always_ff @(posedge clk)
        err_q <= reset ? 1'b0 : err_q | expired;
`else
    assign expired = 1'b0;
    assign bus.err = 1'b0;
`endif

    // Handshake FSM: launch head word, wait ack high, wait ack low; ERR traps a stalled peer
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bus.req_out  <= 1'b0;
            bus.data_out <= '0;
        end else if (expired) begin
            state       <= ERR;
            bus.req_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    bus.data_out <= mem[rd_ptr];
                    bus.req_out  <= 1'b1;
                    state        <= REQ_HI;
                end
                REQ_HI: if (ack_sync) begin
                    bus.req_out <= 1'b0;
                    state       <= ACK_WAIT_LO;
                end
                ACK_WAIT_LO: if (!ack_sync) state <= IDLE;
                default: ;
            endcase
        end
    end
endmodule
